// File: rtl/alerta_pkg.sv
// alerta_pkg -- shared definitions for the seat-belt alert timer.
// Contents:
//   estado_t : FSM state encoding, also visible on the estado debug port.
//   largura  : register width needed to hold every value 0..n-1, never below 1.
package alerta_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    ESPERA   = 2'b01,
    ALERTA   = 2'b10,
    SILENCIO = 2'b11
  } estado_t;

  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gerador_tick.sv
// gerador_tick -- free-running prescaler that emits a one-cycle tick.
// Ports:
//   clk  in  system clock, rising edge
//   clr  in  synchronous clear; the count restarts at 0 on the next edge
//   tick out high for the single cycle in which the count equals CLK_POR_TICK-1
module gerador_tick
  import alerta_pkg::*;
#(
  parameter int CLK_POR_TICK = 50_000_000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int PW = largura(CLK_POR_TICK);
  localparam logic [PW-1:0] PRE_FIM = PW'(CLK_POR_TICK - 1);

  logic [PW-1:0] pre_reg;

  always_ff @(posedge clk) begin
    if (clr || (pre_reg == PRE_FIM)) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  assign tick = (pre_reg == PRE_FIM);

endmodule

// File: rtl/temporizador_alerta.sv
// temporizador_alerta -- seat-belt alert timer.
// After a grace period with the raw warning present, it blinks the lamp and
// sounds the buzzer for a fixed number of ticks, then keeps the lamp steadily
// lit and the buzzer silent. Losing luz or igni returns to idle at once.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   luz     in   raw seat-belt warning
//   igni    in   ignition on
//   lampada out  dashboard lamp drive (registered)
//   buzzer  out  buzzer drive (registered)
//   estado  out  current FSM state (debug)
module temporizador_alerta
  import alerta_pkg::*;
#(
  parameter int CLK_POR_TICK   = 50_000_000,
  parameter int TICKS_CARENCIA = 5,
  parameter int TICKS_ALERTA   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       luz,
  input  logic       igni,
  output logic       lampada,
  output logic       buzzer,
  output logic [1:0] estado
);

  localparam int MAX_TICKS = (TICKS_CARENCIA > TICKS_ALERTA) ? TICKS_CARENCIA : TICKS_ALERTA;
  localparam int CW = largura(MAX_TICKS);
  localparam logic [CW-1:0] FIM_ESPERA = CW'(TICKS_CARENCIA - 1);
  localparam logic [CW-1:0] FIM_ALERTA = CW'(TICKS_ALERTA - 1);

  estado_t       state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          lampada_reg, lampada_next;
  logic          buzzer_reg, buzzer_next;
  logic          entrada;
  logic          tick;

  // Prescaler restarts on reset and on every state change, so each state
  // measures its time from its own entry edge.
  gerador_tick #(
    .CLK_POR_TICK(CLK_POR_TICK)
  ) u_gerador_tick (
    .clk (clk),
    .clr (!rst_n || entrada),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= OCIOSO;
      cnt_reg     <= '0;
      lampada_reg <= 1'b0;
      buzzer_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      lampada_reg <= lampada_next;
      buzzer_reg  <= buzzer_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    lampada_next = lampada_reg;
    buzzer_next  = buzzer_reg;
    entrada      = 1'b0;

    // Abort has priority over every other transition.
    if (!luz || !igni) begin
      state_next = OCIOSO;
    end else begin
      case (state_reg)
        OCIOSO: state_next = ESPERA;
        ESPERA: begin
          if (tick) begin
            if (cnt_reg == FIM_ESPERA) state_next = ALERTA;
            else                       cnt_next   = cnt_reg + 1'b1;
          end
        end
        ALERTA: begin
          if (tick) begin
            if (cnt_reg == FIM_ALERTA) begin
              state_next = SILENCIO;
            end else begin
              cnt_next     = cnt_reg + 1'b1;
              lampada_next = ~lampada_reg;
            end
          end
        end
        SILENCIO: state_next = SILENCIO;
      endcase
    end

    // On entry the counters restart and the outputs take the new state's
    // initial values, so they change on the same edge as the state.
    entrada = (state_next != state_reg);
    if (entrada) begin
      cnt_next = '0;
      case (state_next)
        OCIOSO, ESPERA: begin
          lampada_next = 1'b0;
          buzzer_next  = 1'b0;
        end
        ALERTA: begin
          lampada_next = 1'b1;
          buzzer_next  = 1'b1;
        end
        SILENCIO: begin
          lampada_next = 1'b1;
          buzzer_next  = 1'b0;
        end
      endcase
    end
  end

  assign lampada = lampada_reg;
  assign buzzer  = buzzer_reg;
  assign estado  = state_reg;

endmodule

// File: doc/temporizador_alerta.md
TEMPORIZADOR_ALERTA -- requirements
Module: temporizador_alerta

Interface
REQ-001 SHALL have parameter CLK_POR_TICK, default 50_000_000, clock cycles per tick; legal range >= 2.
REQ-002 SHALL have parameter TICKS_CARENCIA, default 5, grace ticks before alerting; legal range >= 1.
REQ-003 SHALL have parameter TICKS_ALERTA, default 30, ticks of active (blink + buzzer) alert; legal range >= 1.
REQ-004 SHALL provide port: clk  input  1  system clock; every register updates on the rising edge.
REQ-005 SHALL provide port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL provide port: luz  input  1  raw warning from the seat-belt alarm (driver present & belt off & ignition on).
REQ-007 SHALL provide port: igni  input  1  ignition on.
REQ-008 SHALL provide port: lampada  output  1  dashboard lamp drive, registered.
REQ-009 SHALL provide port: buzzer  output  1  buzzer drive, registered.
REQ-010 SHALL provide port: estado  output  2  current FSM state, for debug and the bench.

Function
REQ-011 SHALL implement FSM states OCIOSO=2'b00, ESPERA=2'b01, ALERTA=2'b10, SILENCIO=2'b11; estado SHALL equal the state register.
REQ-012 SHALL apply the abort rule in every state: luz=0 or igni=0 sampled on an edge -> OCIOSO on that edge, with priority over all other transitions.
REQ-013 SHALL move OCIOSO -> ESPERA on the edge where luz=1 and igni=1 are sampled.
REQ-014 SHALL clear the prescaler and the tick counter on every state entry.
REQ-015 SHALL run the prescaler 0..CLK_POR_TICK-1 with wrap; tick=1 for the single cycle in which the prescaler equals CLK_POR_TICK-1.
REQ-016 SHALL, in ESPERA, increment the tick counter on each tick and go to ALERTA on the tick where the counter equals TICKS_CARENCIA-1, i.e. exactly TICKS_CARENCIA*CLK_POR_TICK cycles after ESPERA entry.
REQ-017 SHALL, in ALERTA, hold buzzer=1, set lampada=1 on entry, toggle lampada on each tick, and go to SILENCIO on the tick where the counter equals TICKS_ALERTA-1.
REQ-018 SHALL, in SILENCIO, hold lampada=1 and buzzer=0 until the abort rule applies; there is no exit to ALERTA.
REQ-019 SHALL, in OCIOSO and ESPERA, drive lampada=0 and buzzer=0.
REQ-020 SHALL register both outputs so they change on the same edge as the state transition that causes them.
REQ-021 SHALL size the counters to $clog2 of their maximum value, with no overflow for any legal parameter set.
REQ-022 SHALL treat a luz glitch of 1 cycle in ESPERA as an abort; a fresh ESPERA restarts the full grace period.

Reset
REQ-023 SHALL, when rst_n=0 is sampled, force estado=OCIOSO, lampada=0, buzzer=0, prescaler=0 and tick counter=0, with priority over all inputs.
REQ-024 SHALL, on reset asserted mid-ALERTA or mid-SILENCIO, drive the outputs low on the next edge.
REQ-025 SHALL leave OCIOSO no earlier than the first edge after rst_n returns high.

Structure
REQ-026 SHALL place the state encoding (typedef/localparams) in a shared package, alerta_pkg.
REQ-027 SHALL instantiate one sub-module, gerador_tick (prescaler with synchronous clear input and tick output).
REQ-028 SHALL contain no combinational path from an input to an output.

Verification (CLK_POR_TICK=4, TICKS_CARENCIA=2, TICKS_ALERTA=3)
REQ-029 SHALL cover: luz=1, igni=1 held -> ESPERA 1 cycle later; ALERTA 8 cycles after ESPERA entry; SILENCIO 12 cycles after ALERTA entry; lampada pattern 1,0,1 across the 4-cycle ticks in ALERTA; buzzer=1 only in ALERTA.
REQ-030 SHALL cover: luz drops at cycle 5 of ESPERA -> OCIOSO on the next edge; lampada and buzzer never asserted.
REQ-031 SHALL cover: igni=0 during ALERTA -> OCIOSO, lampada=0 and buzzer=0 on the next edge.
REQ-032 SHALL cover: rst_n=0 for 1 cycle in SILENCIO -> all outputs 0 and estado=00 on that edge; with luz still 1, ESPERA on the first edge after release.
REQ-033 SHALL cover: a 1-cycle luz low pulse in ESPERA, then luz=1 again -> grace period restarts, with ALERTA exactly 8 cycles after the second ESPERA entry.
